ahb_sram_sub: RTL and testbench

AHB subordinate (responder) fronting a word-addressed on-chip register-file memory. It is the target-side counterpart to the bus manager and drives `readyOut`, `resp` and `rData` back to the interconnect. It supports single and burst transfers, little-endian byte and halfword lanes, and a parameterised number of wait states. An optional two-cycle ERROR response covers illegal accesses.

---
 rtl/ahb_sram_sub.sv | 151 +++++++++++++++
 tb/tb_ahb_sram_sub.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_sub.sv
// AHB subordinate fronting a word-addressed register-file memory, with byte lanes and wait states.
// Define AHB_SRAM_SUB_ERR_EN to issue two-cycle ERROR responses on illegal accesses.
module ahb_sram_sub #(
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned Depth      = 256,
  parameter int unsigned WaitStates = 0
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 sel,
  input  logic [AddrWidth-1:0] addr,
  input  logic                 write,
  input  logic [2:0]           size,
  input  logic [2:0]           burst,
  input  logic [1:0]           trans,
  input  logic [DataWidth-1:0] wData,
  input  logic                 readyIn,
  output logic                 readyOut,
  output logic                 resp,
  output logic [DataWidth-1:0] rData
);

  localparam int unsigned ByteW = DataWidth / 8;
  localparam int unsigned LgB   = $clog2(ByteW);
  localparam int unsigned LgD   = $clog2(Depth);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t               r_state;
  logic [2:0]           r_wcnt;
  logic                 r_readyOut;
  logic                 r_resp;
  logic                 r_write;
  logic [LgD-1:0]       r_idx;
  logic [ByteW-1:0]     r_strb;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_cap;
  logic                 w_illegal;
  logic                 w_over;
  logic [LgB-1:0]       w_lane;
  logic [LgB-1:0]       w_off;
  logic [2:0]           w_esize;
  logic [3:0]           w_nbytes;
  logic [ByteW-1:0]     w_strb;
  logic [LgD-1:0]       w_idx;
  logic                 w_unused;

  assign w_cap    = sel & readyIn & trans[1];
  assign w_lane   = addr[LgB-1:0];
  assign w_idx    = addr[LgB +: LgD];

  // Oversize collapses to a full word; lane offset is rounded down to the transfer size.
  assign w_over   = size > 3'(LgB);
  assign w_esize  = w_over ? 3'(LgB) : size;
  assign w_off    = w_lane & ~LgB'((9'd1 << w_esize) - 9'd1);
  assign w_nbytes = 4'(4'd1 << w_esize);
  assign w_strb   = ByteW'(((16'd1 << w_nbytes) - 16'd1) << w_off);

`ifdef AHB_SRAM_SUB_ERR_EN
  logic                 w_unal;
  logic [AddrWidth-1:0] w_hi;
  assign w_unal    = |(w_lane & LgB'((9'd1 << size) - 9'd1));
  assign w_hi      = addr >> (LgB + LgD);
  assign w_illegal = w_over | w_unal | (|w_hi);
  assign resp      = r_resp;
`else
  assign w_illegal = 1'b0;
  assign resp      = 1'b0;
`endif

  assign w_unused = ^{burst, trans[0], addr, r_resp};

  assign readyOut = r_readyOut;
  assign rData    = (r_state == S_DATA) ? r_mem[r_idx] : '0;

  // Transfer FSM: a capture always restarts the data-phase sequence.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_IDLE;
      r_wcnt     <= 3'd0;
      r_readyOut <= 1'b1;
      r_resp     <= 1'b0;
      r_write    <= 1'b0;
      r_idx      <= '0;
      r_strb     <= '0;
    end else if (w_cap) begin
      r_idx   <= w_idx;
      r_write <= write;
      r_strb  <= w_strb;
      if (w_illegal) begin
        r_state    <= S_ERR1;
        r_wcnt     <= 3'd0;
        r_readyOut <= 1'b0;
        r_resp     <= 1'b1;
      end else if (WaitStates > 0) begin
        r_state    <= S_WAIT;
        r_wcnt     <= 3'd1;
        r_readyOut <= 1'b0;
        r_resp     <= 1'b0;
      end else begin
        r_state    <= S_DATA;
        r_wcnt     <= 3'd0;
        r_readyOut <= 1'b1;
        r_resp     <= 1'b0;
      end
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_wcnt == 3'(WaitStates)) begin
            r_state    <= S_DATA;
            r_wcnt     <= 3'd0;
            r_readyOut <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt + 3'd1;
          end
        end
        S_ERR1: begin
          r_state    <= S_ERR2;
          r_readyOut <= 1'b1;
          r_resp     <= 1'b1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_wcnt     <= 3'd0;
          r_readyOut <= 1'b1;
          r_resp     <= 1'b0;
        end
      endcase
    end
  end

  // Write commit on the edge that completes a write data phase.
  always_ff @(posedge clk) begin
    if (r_state == S_DATA && r_write) begin
      for (int unsigned b = 0; b < ByteW; b++) begin
        if (r_strb[b]) begin
          r_mem[r_idx][8*b +: 8] <= wData[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Bench for ahb_sram_sub: two instances (0 and 3 wait states) against a cycle-schedule memory model.
module tb_ahb_sram_sub;

  localparam int unsigned BW    = 4;
  localparam int unsigned LGB   = 2;
  localparam int unsigned DEPTH = 256;
  localparam int          MAXC  = 1024;

  typedef struct packed {
    bit          vld;
    bit          rdy;
    bit          rsp;
    bit          wr;
    bit          rd;
    int unsigned idx;
    int unsigned off;
    int unsigned cnt;
  } ent_t;

  logic        clk = 1'b0;
  logic        nReset;
  logic        sel;
  logic [31:0] addr;
  logic        write;
  logic [2:0]  size;
  logic [2:0]  burst;
  logic [1:0]  trans;
  logic [31:0] wData;
  int          tgt;

  wire         sel0 = sel & (tgt == 0);
  wire         sel3 = sel & (tgt == 1);
  wire         ro0, ro3, rs0, rs3;
  wire  [31:0] rd0, rd3;
  wire         w_ro = (tgt == 1) ? ro3 : ro0;
  wire         w_rs = (tgt == 1) ? rs3 : rs0;
  wire  [31:0] w_rd = (tgt == 1) ? rd3 : rd0;

  ahb_sram_sub #(.AddrWidth(32), .DataWidth(32), .Depth(256), .WaitStates(0)) u_dut0 (
    .clk(clk), .nReset(nReset), .sel(sel0), .addr(addr), .write(write), .size(size),
    .burst(burst), .trans(trans), .wData(wData), .readyIn(ro0),
    .readyOut(ro0), .resp(rs0), .rData(rd0));

  ahb_sram_sub #(.AddrWidth(32), .DataWidth(32), .Depth(256), .WaitStates(3)) u_dut3 (
    .clk(clk), .nReset(nReset), .sel(sel3), .addr(addr), .write(write), .size(size),
    .burst(burst), .trans(trans), .wData(wData), .readyIn(ro3),
    .readyOut(ro3), .resp(rs3), .rData(rd3));

  always #5 clk = ~clk;

  ent_t        sch [2][MAXC];
  bit   [7:0]  mm  [2][DEPTH*BW];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] mword(input int d, input int unsigned idx);
    return {mm[d][idx*BW+3], mm[d][idx*BW+2], mm[d][idx*BW+1], mm[d][idx*BW]};
  endfunction

  // Lay out the expected data-phase cycles of one captured transfer starting at cycle st.
  task automatic sched(input int d, input int st, input int unsigned a, input bit wr,
                       input int unsigned sz);
    int          w;
    int unsigned es;
    bit          bad;
    ent_t        e;
    w   = (d == 1) ? 3 : 0;
    bad = (sz > LGB) || ((a % (32'd1 << sz)) != 0) || ((a / BW) >= DEPTH);
`ifndef AHB_SRAM_SUB_ERR_EN
    bad = 1'b0;
`endif
    if (st + w + 2 >= MAXC) return;
    e = '0;
    e.vld = 1'b1;
    if (bad) begin
      e.rsp = 1'b1;
      sch[d][st] = e;
      e.rdy = 1'b1;
      sch[d][st+1] = e;
    end else begin
      for (int j = 0; j < w; j++) sch[d][st+j] = e;
      es    = (sz > LGB) ? LGB : sz;
      e.rdy = 1'b1;
      e.wr  = wr;
      e.rd  = !wr;
      e.idx = (a / BW) % DEPTH;
      e.off = (a % BW) - (a % (32'd1 << es));
      e.cnt = 32'd1 << es;
      sch[d][st+w] = e;
    end
  endtask

  // Model step at each edge: commit the write finishing now, then schedule any new capture.
  always @(posedge clk) begin : model
    int   k;
    ent_t e;
    k   = cyc;
    cyc = cyc + 1;
    if (nReset && k < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        e = sch[d][k];
        if (e.vld && e.rdy && !e.rsp && e.wr)
          for (int unsigned b = e.off; b < e.off + e.cnt; b++)
            mm[d][e.idx*BW+b] = wData[8*b +: 8];
        if ((d == 0 ? sel0 : sel3) && trans[1] && (!e.vld || e.rdy))
          sched(d, cyc, addr, write, 32'(size));
      end
    end
  end

  always @(negedge clk) begin : cmp
    ent_t        e;
    logic        act_r, act_s;
    logic [31:0] act_d;
    for (int d = 0; d < 2; d++) begin
      e     = (cyc < MAXC) ? sch[d][cyc] : '0;
      act_r = (d == 1) ? ro3 : ro0;
      act_s = (d == 1) ? rs3 : rs0;
      act_d = (d == 1) ? rd3 : rd0;
      check(d == 1 ? "m_ready3" : "m_ready0", 64'(act_r), e.vld ? 64'(e.rdy) : 64'd1);
      check(d == 1 ? "m_resp3" : "m_resp0", 64'(act_s), e.vld ? 64'(e.rsp) : 64'd0);
      if (e.vld && e.rdy && !e.rsp && e.rd)
        check(d == 1 ? "m_rdata3" : "m_rdata0", 64'(act_d), 64'(mword(d, e.idx)));
      else if (!(e.vld && e.rdy && !e.rsp && e.wr))
        check(d == 1 ? "m_rzero3" : "m_rzero0", 64'(act_d), 64'd0);
    end
  end

  int          nb;
  bit          bt_sel   [16];
  logic [31:0] bt_addr  [16];
  bit          bt_wr    [16];
  logic [2:0]  bt_size  [16];
  logic [1:0]  bt_trans [16];
  logic [31:0] bt_data  [16];
  int          w_cnt    [17];
  logic        rsp_at   [17];
  logic [31:0] rd_at    [17];

  task automatic beat(input bit s, input logic [1:0] t, input logic [31:0] a, input bit w,
                      input logic [2:0] sz, input logic [31:0] dat);
    bt_sel[nb]   = s;
    bt_trans[nb] = t;
    bt_addr[nb]  = a;
    bt_wr[nb]    = w;
    bt_size[nb]  = sz;
    bt_data[nb]  = dat;
    nb++;
  endtask

  // Pipelined manager: entry i drives beat i's address phase and beat i-1's write data.
  task automatic run_seq(input int d);
    bit done;
    tgt = d;
    for (int i = 0; i <= nb; i++) begin
      if (i < nb) begin
        sel = bt_sel[i]; addr = bt_addr[i]; write = bt_wr[i];
        size = bt_size[i]; trans = bt_trans[i];
      end else begin
        sel = 1'b0; addr = '0; write = 1'b0; size = 3'd0; trans = 2'd0;
      end
      wData     = (i > 0) ? bt_data[i-1] : 32'd0;
      w_cnt[i]  = 0;
      rsp_at[i] = 1'b0;
      rd_at[i]  = '0;
      done      = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        if (w_ro) begin
          rsp_at[i] = w_rs;
          rd_at[i]  = w_rd;
          done      = 1'b1;
        end else begin
          w_cnt[i]++;
        end
        @(posedge clk); #2;
      end
      check("seq_ready_seen", 64'(done), 64'd1);
    end
    wData = '0;
    nb    = 0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    nReset = 1'b1; sel = 1'b0; addr = '0; write = 1'b0; size = 3'd0;
    burst = 3'd0; trans = 2'd0; wData = '0; tgt = 0; nb = 0;
    #1 nReset = 1'b0;
    #1;
    check("rst_ready0", 64'(ro0), 64'd1);
    check("rst_resp0",  64'(rs0), 64'd0);
    check("rst_rdata0", 64'(rd0), 64'd0);
    check("rst_ready3", 64'(ro3), 64'd1);
    repeat (3) @(posedge clk);
    #2 nReset = 1'b1;
    @(posedge clk); #2;

    // Word write then back-to-back read, zero wait
    beat(1, 2'd2, 32'h10, 1, 3'd2, 32'hDEADBEEF);
    beat(1, 2'd2, 32'h10, 0, 3'd2, 32'h0);
    run_seq(0);
    check("t1_rdata",  64'(rd_at[2]), 64'hDEADBEEF);
    check("t1_nowait", 64'(w_cnt[1] + w_cnt[2]), 64'd0);

    // Byte lane merge
    beat(1, 2'd2, 32'h10, 1, 3'd2, 32'h11223344);
    beat(1, 2'd2, 32'h11, 1, 3'd0, 32'h0000AA00);
    beat(1, 2'd2, 32'h10, 0, 3'd2, 32'h0);
    run_seq(0);
    check("t2_bytelane", 64'(rd_at[3]), 64'h1122AA44);

    // Three wait states: INCR write burst then INCR read burst
    burst = 3'd1;
    beat(1, 2'd2, 32'h20, 1, 3'd2, 32'h01020304);
    beat(1, 2'd3, 32'h24, 1, 3'd2, 32'h05060708);
    beat(1, 2'd3, 32'h28, 1, 3'd2, 32'h090A0B0C);
    beat(1, 2'd3, 32'h2C, 1, 3'd2, 32'h0D0E0F10);
    run_seq(1);
    beat(1, 2'd2, 32'h20, 0, 3'd2, 32'h0);
    beat(1, 2'd3, 32'h24, 0, 3'd2, 32'h0);
    beat(1, 2'd3, 32'h28, 0, 3'd2, 32'h0);
    beat(1, 2'd3, 32'h2C, 0, 3'd2, 32'h0);
    run_seq(1);
    burst = 3'd0;
    for (int i = 1; i <= 4; i++) check("t3_waits", 64'(w_cnt[i]), 64'd3);
    check("t3_beat0", 64'(rd_at[1]), 64'h01020304);
    check("t3_beat1", 64'(rd_at[2]), 64'h05060708);
    check("t3_beat2", 64'(rd_at[3]), 64'h090A0B0C);
    check("t3_beat3", 64'(rd_at[4]), 64'h0D0E0F10);

    // Unaligned, out-of-range and oversize accesses
    beat(1, 2'd2, 32'h13,  0, 3'd1, 32'h0);
    beat(1, 2'd2, 32'h13,  1, 3'd1, 32'h55660000);
    beat(1, 2'd2, 32'h10,  0, 3'd2, 32'h0);
    beat(1, 2'd2, 32'h410, 0, 3'd2, 32'h0);
    beat(1, 2'd2, 32'h10,  0, 3'd3, 32'h0);
    run_seq(0);
`ifdef AHB_SRAM_SUB_ERR_EN
    check("t4_err1_wait", 64'(w_cnt[1]), 64'd1);
    check("t4_err2_resp", 64'(rsp_at[1]), 64'd1);
    check("t4_err_rzero", 64'(rd_at[1]), 64'd0);
    check("t4_werr_resp", 64'(rsp_at[2]), 64'd1);
    check("t4_unchanged", 64'(rd_at[3]), 64'h1122AA44);
    check("t4_oor_resp",  64'(rsp_at[4]), 64'd1);
    check("t4_over_resp", 64'(rsp_at[5]), 64'd1);
`else
    check("t4_unal_wait", 64'(w_cnt[1]), 64'd0);
    check("t4_unal_resp", 64'(rsp_at[1]), 64'd0);
    check("t4_unal_rd",   64'(rd_at[1]), 64'h1122AA44);
    check("t4_unal_wr",   64'(rd_at[3]), 64'h5566AA44);
    check("t4_wrap_rd",   64'(rd_at[4]), 64'h5566AA44);
    check("t4_over_rd",   64'(rd_at[5]), 64'h5566AA44);
`endif

    // BUSY, ignored select and IDLE add no wait and no response
    beat(1, 2'd1, 32'h10, 0, 3'd2, 32'h0);
    beat(0, 2'd2, 32'h13, 0, 3'd1, 32'h0);
    beat(1, 2'd0, 32'h10, 0, 3'd2, 32'h0);
    beat(1, 2'd2, 32'h10, 0, 3'd2, 32'h0);
    run_seq(0);
    check("t5_nowait", 64'(w_cnt[1] + w_cnt[2] + w_cnt[3]), 64'd0);
    check("t5_noresp", 64'(rsp_at[2] | rsp_at[3] | rsp_at[4]), 64'd0);
    check("t5_rzero",  64'(rd_at[3]), 64'd0);
`ifdef AHB_SRAM_SUB_ERR_EN
    check("t5_rd", 64'(rd_at[4]), 64'h1122AA44);
`else
    check("t5_rd", 64'(rd_at[4]), 64'h5566AA44);
`endif

    // Reset during a write wait state aborts the write
    tgt = 1; sel = 1'b1; addr = 32'h20; write = 1'b1; size = 3'd2; trans = 2'd2;
    @(posedge clk); #2;
    sel = 1'b0; trans = 2'd0; write = 1'b0; wData = 32'h99999999;
    #1 check("t6_in_wait", 64'(ro3), 64'd0);
    nReset = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int k = cyc; k < MAXC; k++) sch[d][k] = '0;
    #1;
    check("t6_rst_ready", 64'(ro3), 64'd1);
    check("t6_rst_resp",  64'(rs3), 64'd0);
    check("t6_rst_rdata", 64'(rd3), 64'd0);
    repeat (2) @(posedge clk);
    #2 nReset = 1'b1; wData = '0;
    @(posedge clk); #2;
    beat(1, 2'd2, 32'h20, 0, 3'd2, 32'h0);
    run_seq(1);
    check("t6_nocommit", 64'(rd_at[1]), 64'h01020304);
    check("t6_waits",    64'(w_cnt[1]), 64'd3);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
